// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a big-endian byte stream into 16-bit words, writes them
// to instruction RAM at word addresses 0..WORDS-1, checks a trailing 8-bit checksum.
module instr_mem_loader #(
    parameter int ADDR_W = 4,
    parameter int WORDS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_written
);
    typedef enum logic [2:0] {IDLE, HI, LO, WR, CHK} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W:0]   WORDS_W   = (ADDR_W + 1)'(WORDS);

    state_t            state, state_next;
    logic [7:0]        hi_reg, sum;
    logic [ADDR_W-1:0] addr;
    logic              accept, last;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_next;

    always_comb begin
        rx_ready   = (state == HI) || (state == LO) || (state == CHK);
        accept     = rx_valid && rx_ready;
        last       = addr == LAST_ADDR;
        state_next = (state == IDLE && start)  ? HI :
                     (state == HI && accept)   ? LO :
                     (state == LO && accept)   ? WR :
                     (state == WR)             ? (last ? CHK : HI) :
                     (state == CHK && accept)  ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_hold      <= 1'b0;
            words_written <= '0;
            hi_reg        <= '0;
            sum           <= '0;
            addr          <= '0;
        end else begin
            wr_en <= state == LO && accept;
            if (state == IDLE && start) begin
                busy          <= 1'b1;
                cpu_hold      <= 1'b1;
                done          <= 1'b0;
                error         <= 1'b0;
                sum           <= '0;
                addr          <= '0;
                words_written <= '0;
            end
            if (accept && state != CHK) sum <= sum + rx_data;
            if (state == HI && accept) hi_reg <= rx_data;
            if (state == LO && accept) begin
                wr_data <= {hi_reg, rx_data};
                wr_addr <= addr;
            end
            if (state == WR) begin
                if (words_written != WORDS_W) words_written <= words_written + 1'b1;
                if (!last) addr <= addr + 1'b1;
            end
            // cpu_hold is only released by a matching checksum
            if (state == CHK && accept) begin
                busy     <= 1'b0;
                done     <= rx_data == sum;
                error    <= rx_data != sum;
                cpu_hold <= rx_data != sum;
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: random image loads checked against a byte-array model of the
// expected write sequence, checksum and completion flags.
module tb_instr_mem_loader;
    logic       clk, reset, start1, start2, rx_valid1, rx_valid2;
    logic [7:0] rx_data;
    logic       rx_ready1, wr_en1, busy1, done1, error1, cpu_hold1;
    logic       rx_ready2, wr_en2, busy2, done2, error2, cpu_hold2;
    logic [3:0] wr_addr1, wr_addr2;
    logic [15:0] wr_data1, wr_data2;
    logic [4:0] words_written1, words_written2;

    int n_chk = 0, n_pass = 0;
    logic [7:0]  img[32];
    logic [19:0] q1[$], q2[$];

    instr_mem_loader #(.ADDR_W(4), .WORDS(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rx_data(rx_data), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1), .error(error1), .cpu_hold(cpu_hold1),
        .words_written(words_written1));

    instr_mem_loader #(.ADDR_W(4), .WORDS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rx_data(rx_data), .rx_valid(rx_valid2),
        .rx_ready(rx_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .done(done2), .error(error2), .cpu_hold(cpu_hold2),
        .words_written(words_written2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (wr_en1) begin
            q1.push_back({wr_addr1, wr_data1});
            check("rx_ready_in_wr", 32'(rx_ready1), 0);
        end
        if (wr_en2) begin
            q2.push_back({wr_addr2, wr_data2});
            check("rx_ready_in_wr2", 32'(rx_ready2), 0);
        end
    end

    function automatic logic [7:0] img_sum(input int nb);
        int s = 0;
        for (int i = 0; i < nb; i++) s += img[i];
        return 8'(s);
    endfunction

    task automatic pulse_start(input bit s);
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send(input bit s, input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) @(posedge clk);
        #1;
        rx_data = b;
        if (s) rx_valid2 = 1'b1; else rx_valid1 = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = s ? rx_ready2 : rx_ready1;
        end
        if (ok) @(posedge clk);
        else check("rx_ready_timeout", 0, 1);
        #1;
        rx_valid1 = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic load(input bit s, input int nw, input int maxgap, input int glitch_word,
                        input logic [7:0] mask);
        if (s) q2.delete(); else q1.delete();
        pulse_start(s);
        for (int i = 0; i < 2 * nw; i++) begin
            send(s, img[i], $urandom_range(0, maxgap));
            if (i == 2 * glitch_word) pulse_start(s);
        end
        send(s, img_sum(2 * nw) ^ mask, $urandom_range(0, maxgap));
        @(negedge clk);
    endtask

    task automatic verify(input bit s, input int nw, input bit ok);
        logic [19:0] q[$];
        q = s ? q2 : q1;
        check("n_writes", q.size(), nw);
        for (int i = 0; i < nw && i < q.size(); i++) begin
            check("wr_addr", 32'(q[i][19:16]), i);
            check("wr_data", 32'(q[i][15:0]), {img[2*i], img[2*i+1]});
        end
        check("done", 32'(s ? done2 : done1), ok);
        check("error", 32'(s ? error2 : error1), !ok);
        check("cpu_hold", 32'(s ? cpu_hold2 : cpu_hold1), !ok);
        check("busy", 32'(s ? busy2 : busy1), 0);
        check("words_written", 32'(s ? words_written2 : words_written1), nw);
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_busy"}, 32'(busy1), 0);
        check({tag, "_done"}, 32'(done1), 0);
        check({tag, "_error"}, 32'(error1), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold1), 0);
        check({tag, "_wr_en"}, 32'(wr_en1), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr1), 0);
        check({tag, "_wr_data"}, 32'(wr_data1), 0);
        check({tag, "_words"}, 32'(words_written1), 0);
        check({tag, "_rx_ready"}, 32'(rx_ready1), 0);
    endtask

    task automatic rand_img();
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1; start1 = 0; start2 = 0; rx_valid1 = 0; rx_valid2 = 0; rx_data = 0;
        repeat (2) @(posedge clk);
        #1 check_idle1("reset");
        @(negedge clk) reset = 1'b0;

        rand_img();
        img[0] = 8'h44; img[1] = 8'h42; img[2] = 8'h44; img[3] = 8'hC1;
        load(0, 16, 0, -1, 8'h00);
        verify(0, 16, 1);
        check("first_word", q1.size() > 0 ? 32'(q1[0][15:0]) : 0, 32'h4442);
        check("second_word", q1.size() > 1 ? 32'(q1[1][15:0]) : 0, 32'h44C1);

        load(0, 16, 0, -1, 8'h01);
        verify(0, 16, 0);

        load(0, 16, 5, -1, 8'h00);
        verify(0, 16, 1);

        rand_img();
        q1.delete();
        pulse_start(0);
        for (int i = 0; i < 7; i++) send(0, img[i], 0);
        #2 reset = 1'b1;
        #1 check_idle1("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        check("writes_before_reset", q1.size(), 3);
        load(0, 16, 2, -1, 8'h00);
        verify(0, 16, 1);

        rand_img();
        load(0, 16, 2, 5, 8'h00);
        verify(0, 16, 1);

        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'hAB; img[3] = 8'hCD;
        load(1, 2, 1, -1, 8'h00);
        verify(1, 2, 1);
        check("w2_word0", q2.size() > 0 ? 32'(q2[0]) : 0, 32'h01234);
        check("w2_word1", q2.size() > 1 ? 32'(q2[1]) : 0, 32'h1ABCD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
